// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory port arbiter.
package riscv_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned RUN_W      = 4;
    localparam int unsigned TMO_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Also serves as the bit index into the grant vector.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: data over fetch, except that fetch wins once
// data has taken MAX_DATA_RUN consecutive grants while fetch was waiting.
module mem_arb_pick
    import riscv_mem_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [RUN_W-1:0] run_cnt,
    output logic [1:0]       gnt,
    output logic [RUN_W-1:0] run_cnt_nxt
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    logic fetch_starved;

    assign fetch_starved = if_req && (run_cnt >= RUN_MAX);

    always_comb begin
        gnt         = '0;
        run_cnt_nxt = run_cnt;
        if (d_req && !fetch_starved) begin
            gnt[OWN_D] = 1'b1;
            // A data win only extends the run when fetch is actually waiting.
            run_cnt_nxt = if_req ? run_cnt + RUN_W'(1) : '0;
        end else if (if_req) begin
            gnt[OWN_IF] = 1'b1;
            run_cnt_nxt = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port,
// with a registered request/response handshake and a per-access timeout.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t           state;
    owner_t           owner;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       pick_gnt;
    logic [1:0]       gnt;
    logic             tmo_hit;

    mem_arb_pick #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .run_cnt    (run_cnt),
        .gnt        (pick_gnt),
        .run_cnt_nxt(run_cnt_nxt)
    );

    assign gnt     = (state == ST_IDLE) ? pick_gnt : '0;
    assign if_gnt  = gnt[OWN_IF];
    assign d_gnt   = gnt[OWN_D];
    assign busy    = (state != ST_IDLE);
    assign tmo_hit = (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            run_cnt   <= '0;
            tmo_cnt   <= '0;
            rdata     <= '0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt != '0) begin
                        state   <= ST_BUSY;
                        run_cnt <= run_cnt_nxt;
                        tmo_cnt <= '0;
                        mem_en  <= 1'b1;
                        if (gnt[OWN_D]) begin
                            owner     <= OWN_D;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            owner     <= OWN_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // A ready arriving on the timeout cycle still completes normally.
                    if (mem_ready || tmo_hit) begin
                        state  <= ST_RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        rdata  <= (mem_ready && !mem_we) ? mem_rdata : '0;
                        err    <= !mem_ready;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                        end else begin
                            if_rvalid <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_RUN = 4;
    localparam int unsigned TMO     = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned streak   = 0;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_arr [256];

    typedef struct {
        logic        ir;
        logic        dr;
        logic        we;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] mdata;
        int unsigned lat;
        logic        exp_dwin;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [16];

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_DATA_RUN(MAX_RUN),
        .TIMEOUT     (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .err      (err),
        .busy     (busy),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: data first, fetch after MAX_RUN straight data wins it waited through.
    task automatic model_arb(input logic ir, input logic dr, output logic dwin);
        dwin = dr && !(ir && streak == MAX_RUN);
        if (dwin && ir) streak++;
        else streak = 0;
    endtask

    // One full access from an IDLE cycle; lat = BUSY cycle carrying mem_ready, 0 = never.
    task automatic do_txn(input string tag, input logic ir, input logic dr, input logic we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          input int unsigned lat, input logic exp_dwin,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] exp_addr;
        logic        exp_we;
        int unsigned last;
        exp_addr = exp_dwin ? da : ia;
        exp_we   = exp_dwin & we;
        last     = (lat == 0) ? TMO + 1 : lat;
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        mem_ready = 1'b0; mem_rdata = $urandom;
        @(negedge clk);
        chk({tag, " gnt"}, {62'd0, if_gnt, d_gnt}, exp_dwin ? 64'd1 : 64'd2);
        chk({tag, " busy0"}, {63'd0, busy}, 64'd0);
        for (int unsigned k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if_req = 1'b0; d_req = 1'b0;
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            mem_ready = (lat != 0) && (k == lat);
            mem_rdata = $urandom;
            if (mem_ready) begin
                if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
                else mem_rdata = mem_arr[mem_addr[9:2]];
            end
            @(negedge clk);
            chk({tag, " mem_en"}, {63'd0, mem_en}, 64'd1);
            chk({tag, " mem_we"}, {63'd0, mem_we}, {63'd0, exp_we});
            chk({tag, " mem_addr"}, {32'd0, mem_addr}, {32'd0, exp_addr});
            if (exp_we) chk({tag, " mem_wdata"}, {32'd0, mem_wdata}, {32'd0, wd});
            chk({tag, " early_rvalid"}, {62'd0, if_rvalid, d_rvalid}, 64'd0);
        end
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        chk({tag, " rvalid"}, {62'd0, if_rvalid, d_rvalid}, exp_dwin ? 64'd1 : 64'd2);
        chk({tag, " rdata"}, {32'd0, rdata}, {32'd0, exp_rdata});
        chk({tag, " err"}, {63'd0, err}, {63'd0, exp_err});
        chk({tag, " resp_mem_en"}, {63'd0, mem_en}, 64'd0);
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        @(negedge clk);
        chk({tag, " idle_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, " idle_rvalid"}, {62'd0, if_rvalid, d_rvalid}, 64'd0);
    endtask

    initial begin
        logic        dwin;
        logic        ir, dr, we;
        logic [31:0] ia, da, wd, exp_rd;
        logic [1:0]  exp_g;
        logic [1:0]  r2;
        vec_t        v;

        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h40, 32'h0,        32'hDEADBEEF, 1, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h44, 32'h12345678, 32'h0,        3, 1'b1, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,  32'h0,        32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h48, 32'h0,        32'h11111111, 1, 1'b1, 32'h11111111, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h4C, 32'h0,        32'h22222222, 1, 1'b1, 32'h22222222, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h50, 32'h0,        32'h33333333, 1, 1'b1, 32'h33333333, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h54, 32'h0,        32'h44444444, 2, 1'b1, 32'h44444444, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h58, 32'h0,        32'h55555555, 1, 1'b0, 32'h55555555, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h5C, 32'h0,        32'h66666666, 1, 1'b1, 32'h66666666, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h60, 32'hA5A5A5A5, 32'h0,        2, 1'b1, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h64, 32'h0,        32'h77777777, 1, 1'b1, 32'h77777777, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h68, 32'h0,        32'h88888888, 1, 1'b1, 32'h88888888, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h6C, 32'h0,        32'h99999999, 1, 1'b1, 32'h99999999, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h70, 32'h0,        32'hAAAAAAAA, 1, 1'b1, 32'hAAAAAAAA, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h10C, 32'h74, 32'h0,        32'hBBBBBBBB, 1, 1'b0, 32'hBBBBBBBB, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h110, 32'h0,  32'h0,        32'hCCCCCCCC, 3, 1'b0, 32'hCCCCCCCC, 1'b0};

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset mem_en", {63'd0, mem_en}, 64'd0);
        chk("reset mem_we", {63'd0, mem_we}, 64'd0);
        chk("reset mem_addr", {32'd0, mem_addr}, 64'd0);
        chk("reset mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("reset rdata", {32'd0, rdata}, 64'd0);
        chk("reset rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        chk("reset err", {63'd0, err}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            v = tbl[i];
            if (v.exp_dwin && !v.we) mem_arr[v.da[9:2]] = v.mdata;
            if (!v.exp_dwin) mem_arr[v.ia[9:2]] = v.mdata;
            do_txn($sformatf("vec%0d", i), v.ir, v.dr, v.we, v.ia, v.da, v.wd, v.lat,
                   v.exp_dwin, v.exp_rdata, v.exp_err);
        end

        // Both requests held with an always-ready memory: one grant every three cycles.
        streak = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; if_addr = 32'h200;
            mem_ready = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            exp_g = 2'b00;
            if (c % 3 == 0) begin
                model_arb(1'b1, 1'b1, dwin);
                exp_g = dwin ? 2'b01 : 2'b10;
            end
            chk($sformatf("contend%0d", c), {62'd0, if_gnt, d_gnt}, {62'd0, exp_g});
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("contend settle", {63'd0, busy}, 64'd0);

        do_txn("tmo_abort", 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0, 32'h0, 1'b1);
        mem_arr[8'hC1] = 32'h0BADF00D;
        do_txn("tmo_255", 1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h0, 255, 1'b0, 32'h0BADF00D, 1'b0);
        mem_arr[8'hC2] = 32'h600DCAFE;
        do_txn("tmo_256", 1'b1, 1'b0, 1'b0, 32'h308, 32'h0, 32'h0, 256, 1'b0, 32'h600DCAFE, 1'b0);

        // Reset during the second BUSY cycle abandons the access.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_ready = 1'b0;
        @(negedge clk);
        chk("rstmid gnt", {63'd0, d_gnt}, 64'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("rstmid busy1", {63'd0, mem_en}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid mem_en", {63'd0, mem_en}, 64'd0);
        chk("rstmid busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            mem_ready = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            chk($sformatf("stray%0d rvalid", c), {62'd0, if_rvalid, d_rvalid}, 64'd0);
            chk($sformatf("stray%0d busy", c), {63'd0, busy}, 64'd0);
        end
        mem_ready = 1'b0;
        mem_arr[8'h20] = 32'hFEEDFACE;
        do_txn("post_rst", 1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 1, 1'b1, 32'hFEEDFACE, 1'b0);

        streak = 0;
        for (int i = 0; i < 256; i++) ref_arr[i] = mem_arr[i];
        for (int n = 0; n < 80; n++) begin
            r2 = 2'($urandom_range(1, 3));
            ir = r2[1]; dr = r2[0];
            we = 1'($urandom_range(0, 1));
            ia = 32'($urandom_range(0, 255)) << 2;
            da = 32'($urandom_range(0, 255)) << 2;
            wd = $urandom;
            model_arb(ir, dr, dwin);
            if (dwin) begin
                if (we) begin
                    exp_rd = '0;
                    ref_arr[da[9:2]] = wd;
                end else begin
                    exp_rd = ref_arr[da[9:2]];
                end
            end else begin
                exp_rd = ref_arr[ia[9:2]];
            end
            do_txn($sformatf("rnd%0d", n), ir, dr, we, ia, da, wd,
                   $urandom_range(1, 4), dwin, exp_rd, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
